// File: rtl/dca_lsu_store_aw_gen.sv
// Store AW generator: issues one AXI write burst plus one write-data transaction record per row.
// DCA_LSU_STORE_BRESP_CHECK_EN enables the sticky B-response error flag.
`default_nettype none

module dca_lsu_store_aw_gen #(
  parameter int BW_AXI_ADDR     = 32,
  parameter int BW_AXI_DATA     = 128,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [BW_AXI_ADDR-1:0] cmd_base_addr,
  input  logic [BW_AXI_ADDR-1:0] cmd_row_stride,
  input  logic [15:0]            cmd_num_rows,
  input  logic [7:0]             cmd_len,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [BW_AXI_ADDR-1:0] awaddr,
  output logic [7:0]             awlen,
  output logic [2:0]             awsize,
  output logic [1:0]             awburst,
  output logic                   txn_valid,
  input  logic                   txn_ready,
  output logic [8:0]             txn_info,
  input  logic                   bvalid,
  output logic                   bready,
  input  logic [1:0]             bresp,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int          OUT_W   = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [2:0]  AW_SIZE = 3'($clog2(BW_AXI_DATA / 8));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                 state;
  logic [BW_AXI_ADDR-1:0] row_addr;
  logic [BW_AXI_ADDR-1:0] stride;
  logic [15:0]            rows_left;
  logic [7:0]             len;
  logic                   aw_sent;
  logic                   txn_sent;
  logic [OUT_W-1:0]       outstanding;
  logic [OUT_W-1:0]       out_next;

  logic aw_hs;
  logic txn_hs;
  logic b_hs;
  logic last_row;
  logic row_adv;
  logic drain_done;

  // Budget only shrinks on an AW handshake, so awvalid cannot drop once raised.
  assign awvalid   = (state == ISSUE) && !aw_sent && (outstanding < OUT_W'(MAX_OUTSTANDING));
  assign txn_valid = (state == ISSUE) && !txn_sent;
  assign bready    = (outstanding != '0);
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  assign aw_hs    = awvalid & awready;
  assign txn_hs   = txn_valid & txn_ready;
  assign b_hs     = bvalid & bready;
  assign last_row = (rows_left == 16'd1);
  assign row_adv  = (state == ISSUE) && (aw_sent || aw_hs) && (txn_sent || txn_hs);

  assign awaddr   = row_addr;
  assign awlen    = len;
  assign awsize   = (state == ISSUE) ? AW_SIZE : 3'd0;
  assign awburst  = (state == ISSUE) ? 2'b01 : 2'b00;
  assign txn_info = {last_row, len};

  always_comb begin
    out_next = outstanding;
    if (aw_hs && !b_hs)
      out_next = outstanding + OUT_W'(1);
    else if (b_hs && !aw_hs)
      out_next = outstanding - OUT_W'(1);
  end

  // Counting the B accepted this cycle lets done follow the final response directly.
  assign drain_done = (state == DRAIN) && (out_next == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      row_addr    <= '0;
      stride      <= '0;
      rows_left   <= '0;
      len         <= '0;
      aw_sent     <= 1'b0;
      txn_sent    <= 1'b0;
      outstanding <= '0;
      done        <= 1'b0;
    end else begin
      done        <= 1'b0;
      outstanding <= out_next;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            row_addr  <= cmd_base_addr;
            stride    <= cmd_row_stride;
            rows_left <= cmd_num_rows;
            len       <= cmd_len;
            aw_sent   <= 1'b0;
            txn_sent  <= 1'b0;
            state     <= (cmd_num_rows != 16'd0) ? ISSUE : DRAIN;
          end
        end
        ISSUE: begin
          if (row_adv) begin
            row_addr  <= row_addr + stride;
            rows_left <= rows_left - 16'd1;
            aw_sent   <= 1'b0;
            txn_sent  <= 1'b0;
            if (last_row)
              state <= DRAIN;
          end else begin
            if (aw_hs)
              aw_sent <= 1'b1;
            if (txn_hs)
              txn_sent <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCA_LSU_STORE_BRESP_CHECK_EN
  logic error_q;

  // No B can be in flight in IDLE, so acceptance-clear and set never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      error_q <= 1'b0;
    else if (state == IDLE && cmd_valid)
      error_q <= 1'b0;
    else if (b_hs && bresp != 2'b00)
      error_q <= 1'b1;
  end

  assign error = error_q;
`else
  logic unused_bresp;
  assign unused_bresp = ^bresp;
  assign error        = 1'b0;
`endif

endmodule

`default_nettype wire
